cic_v3: RTL and testbench

Decimating N-stage Cascaded Integrator-Comb (CIC) low-pass filter with differential delay M=1, decimation ratio R and DC gain R^N. It sits in the phasemeter datapath after the mixer. It takes the signed mixer product at the full clock rate and delivers a decimated, bit-grown signed result together with a one-cycle sample-valid strobe.

---
 rtl/cic_pkg.sv | 28 ++
 rtl/cic_integrator.sv | 24 ++
 rtl/cic_v3.sv | 139 +++++++++++++
 tb/tb_cic_v3.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the CIC decimator.
package cic_pkg;

    localparam int unsigned DEF_N            = 2;
    localparam int unsigned DEF_R            = 16;
    localparam int unsigned DEF_INPUT_WIDTH  = 14;
    localparam int unsigned DEF_OUTPUT_WIDTH = 32;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Internal datapath width: input plus N*log2(R) bits of growth.
    function automatic int unsigned cic_width(input int unsigned in_w,
                                              input int unsigned n,
                                              input int unsigned r);
        return in_w + n * clog2(r);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One W-bit wrapping accumulator stage of the CIC integrator cascade.
module cic_integrator #(
    parameter int unsigned W = 22
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_acc
);

    logic [W-1:0] r_acc;

    // Accumulate every clock; modulo 2^W wrap is intentional.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + i_x;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cic_v3.sv
// Decimating N-stage CIC low-pass filter (M=1, gain R^N).
// Optional build macro CIC_INPUT_REG_EN registers inF before the first
// integrator, adding one clock of latency.
module cic_v3
    import cic_pkg::*;
#(
    parameter int unsigned N            = DEF_N,
    parameter int unsigned R            = DEF_R,
    parameter int unsigned INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  inF,
    output logic [OUTPUT_WIDTH-1:0] outF,
    output logic                    d_clk
);

    localparam int unsigned W     = cic_width(INPUT_WIDTH, N, R);
    localparam int unsigned CNT_W = clog2(R);
    localparam int unsigned EXT_W = W - INPUT_WIDTH;

    // ---------------- Input stage ----------------
    logic [INPUT_WIDTH-1:0] w_in;

`ifdef CIC_INPUT_REG_EN
    logic [INPUT_WIDTH-1:0] r_in;

    // Capture the mixer product before integration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in <= '0;
        end else begin
            r_in <= inF;
        end
    end

    assign w_in = r_in;
`else
    assign w_in = inF;
`endif

    logic [W-1:0] w_x;
    assign w_x = {{EXT_W{w_in[INPUT_WIDTH-1]}}, w_in};

    // ---------------- Integrator cascade ----------------
    logic [W-1:0] w_integ [N];

    for (genvar k = 0; k < N; k++) begin : g_integ
        logic [W-1:0] w_stage_in;
        if (k == 0) begin : g_first
            assign w_stage_in = w_x;
        end else begin : g_rest
            assign w_stage_in = w_integ[k-1];
        end

        cic_integrator #(
            .W (W)
        ) u_integ (
            .i_clk (clk),
            .i_rst (rst),
            .i_x   (w_stage_in),
            .o_acc (w_integ[k])
        );
    end

    // ---------------- Decimation counter ----------------
    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;

    assign w_dec = (r_cnt == CNT_W'(R - 1));

    // Free-running modulo-R counter; R is a power of two so it wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---------------- Comb chain ----------------
    logic [W-1:0] r_dly     [N];
    logic [W-1:0] w_comb_in [N];
    logic [W-1:0] w_acc;
    logic [W-1:0] w_comb_out;

    // Combinational difference chain fed by the last integrator.
    always_comb begin
        w_acc = w_integ[N-1];
        for (int k = 0; k < N; k++) begin
            w_comb_in[k] = w_acc;
            w_acc        = w_acc - r_dly[k];
        end
        w_comb_out = w_acc;
    end

    // Comb delay registers advance only at the decimation edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_dly[k] <= '0;
            end
        end else if (w_dec) begin
            for (int k = 0; k < N; k++) begin
                r_dly[k] <= w_comb_in[k];
            end
        end
    end

    // ---------------- Output formatting ----------------
    logic [OUTPUT_WIDTH-1:0] w_out_next;

    if (OUTPUT_WIDTH >= W) begin : g_sext
        assign w_out_next = OUTPUT_WIDTH'($signed(w_comb_out));
    end else begin : g_trunc
        assign w_out_next = w_comb_out[W-1 -: OUTPUT_WIDTH];
    end

    logic [OUTPUT_WIDTH-1:0] r_out;
    logic                    r_dclk;

    // Register the decimated sample and its one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_dclk <= 1'b0;
        end else begin
            r_dclk <= w_dec;
            if (w_dec) begin
                r_out <= w_out_next;
            end
        end
    end

    assign outF  = r_out;
    assign d_clk = r_dclk;

endmodule

// File: tb/tb_cic_v3.sv
// Self-checking bench for cic_v3 (N=2, R=16, 14-bit in, 32-bit out).
// Reference: output sample m is the convolution of the input history with
// the (boxcar of length R)^N kernel, sampled every R clocks.
module tb_cic_v3;

    localparam int N    = 2;
    localparam int R    = 16;
    localparam int IW   = 14;
    localparam int OW   = 32;
    localparam int HL   = N * (R - 1) + 1;
    localparam int MAXT = 32768;
`ifdef CIC_INPUT_REG_EN
    localparam int D = N + 1;
`else
    localparam int D = N;
`endif
    localparam real PI = 3.14159265358979;

    logic          clk;
    logic          rst;
    logic [IW-1:0] inF;
    logic [OW-1:0] outF;
    logic          d_clk;

    cic_v3 #(
        .N            (N),
        .R            (R),
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .inF   (inF),
        .outF  (outF),
        .d_clk (d_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          h [HL];
    int          xs [MAXT];
    int          t;
    logic [31:0] exp_hold;

    typedef struct {
        string name;
        int    din;
        int    exp_out;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0d: got %0d (0x%08h) expected %0d (0x%08h)",
                         name, t, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic longint model_y(input int tt);
        longint s;
        s = 0;
        for (int j = 0; j < HL; j++) begin
            int idx;
            idx = tt - D - j;
            if (idx >= 1) s += longint'(h[j]) * longint'(xs[idx]);
        end
        return s;
    endfunction

    // Apply one clock of stimulus and check outputs 1 time unit after the edge.
    task automatic step(input logic rst_v, input int x);
        logic [31:0] xv;
        xv  = x;
        rst = rst_v;
        inF = xv[IW-1:0];
        @(posedge clk);
        #1;
        if (rst_v) begin
            t        = 0;
            exp_hold = '0;
            chk("rst_outF", outF, 32'd0);
            chk("rst_d_clk", {31'd0, d_clk}, 32'd0);
        end else begin
            logic exp_d;
            t++;
            xs[t] = x;
            exp_d = ((t % R) == 0);
            if (exp_d) exp_hold = 32'(model_y(t));
            chk("d_clk", {31'd0, d_clk}, {31'd0, exp_d});
            chk("outF", outF, exp_hold);
        end
    endtask

    initial begin
        int hp [HL];
        int first;
        int x;

        // Build the (boxcar R)^N kernel.
        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < HL; i++) hp[i] = h[i];
            for (int i = 0; i < HL; i++) begin
                h[i] = 0;
                for (int b = 0; b < R; b++)
                    if (i - b >= 0) h[i] += hp[i - b];
            end
        end

        vecs[0] = '{"dc_pos",   100,   25600};
        vecs[1] = '{"dc_neg",   -1,    -256};
        vecs[2] = '{"fs_neg",   -8192, -2097152};
        vecs[3] = '{"fs_pos",   8191,  2096896};
        vecs[4] = '{"dc_zero",  0,     0};

        t        = 0;
        exp_hold = '0;
        rst      = 1'b1;
        inF      = '0;

        // Reset held 3 clocks with arbitrary input.
        repeat (3) step(1'b1, int'($urandom_range(0, 16383)) - 8192);

        // First strobe must come 16 clocks after release (bounded search).
        first = -1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            step(1'b0, int'($urandom_range(0, 16383)) - 8192);
            if (d_clk) first = i;
        end
        chk("first_d_clk", 32'(first), 32'(R));
        repeat (64) step(1'b0, int'($urandom_range(0, 16383)) - 8192);

        // Table-driven DC and full-scale cases, each from a clean reset.
        for (int v = 0; v < 5; v++) begin
            step(1'b1, 0);
            repeat (6 * R) step(1'b0, vecs[v].din);
            chk($sformatf("%s_settled", vecs[v].name), outF, 32'(vecs[v].exp_out));
        end

        // Mid-run reset at cnt == 7 after random history.
        step(1'b1, 0);
        repeat (50) step(1'b0, int'($urandom_range(0, 16383)) - 8192);
        while ((t % R) != 7) step(1'b0, int'($urandom_range(0, 16383)) - 8192);
        step(1'b1, 1234);
        first = -1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            step(1'b0, 500);
            if (d_clk) first = i;
        end
        chk("midrst_first_d_clk", 32'(first), 32'(R));
        repeat (4 * R) step(1'b0, 500);
        chk("midrst_dc_settled", outF, 32'(500 * 256));

        // Full-range random input.
        step(1'b1, 0);
        repeat (200 * R) step(1'b0, int'($urandom_range(0, 16383)) - 8192);

        // Mixer-like tone: fast sum term + slow difference term + noise.
        step(1'b1, 0);
        for (int i = 1; i <= 1050 * R; i++) begin
            real r;
            r = 4000.0 * $cos(2.0 * PI * 0.41 * real'(i))
              + 3000.0 * $cos(2.0 * PI * 0.0007 * real'(i));
            x = int'(r) + int'($urandom_range(0, 400)) - 200;
            if (x > 8191) x = 8191;
            if (x < -8192) x = -8192;
            step(1'b0, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
